pc_unit: RTL and testbench

- Parametrised next-generation fetch program counter for the single-cycle/pipelined ARM datapath.
- Holds the PC and computes sequential (PC+4) and PC-relative branch targets (19-bit conditional / 26-bit unconditional word offsets).
- Supports an external PC load, a fetch stall, and a return-address stack (RAS) for BL/BR-style call/return.
- Sits between the branch-control logic and instruction memory.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_unit_if.sv | 50 +++++
 rtl/pc_ras.sv | 54 +++++
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and next-PC select encoding for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int WORD_SHIFT  = 2;

  typedef enum logic [2:0] {
    SEL_EXT  = 3'd0,
    SEL_HOLD = 3'd1,
    SEL_RAS  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_SEQ  = 3'd4
  } next_pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_if
// Description : Branch-control / fetch bundle of pc_unit. PC_ALIGN_CHECK_EN
//               adds the pc_misalign status signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int ADDR_W   = 64,
  parameter int COND_W   = 19,
  parameter int UNCOND_W = 26
);
  logic                stall;
  logic                br_taken;
  logic                uncond_br;
  logic [COND_W-1:0]   cond_addr19;
  logic [UNCOND_W-1:0] br_addr26;
  logic                call;
  logic                ret;
  logic                pc_rd;
  logic [ADDR_W-1:0]   pc_ext;
  logic [ADDR_W-1:0]   pc_out;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
  logic                pc_misalign;
`endif

  modport master (
    output stall, br_taken, uncond_br, cond_addr19, br_addr26,
    output call, ret, pc_rd, pc_ext,
`ifdef PC_ALIGN_CHECK_EN
    input  pc_misalign,
`endif
    input  pc_out, pc_plus4, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, br_taken, uncond_br, cond_addr19, br_addr26,
    input  call, ret, pc_rd, pc_ext,
`ifdef PC_ALIGN_CHECK_EN
    output pc_misalign,
`endif
    output pc_out, pc_plus4, ras_empty, ras_full, ras_underflow
  );

endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack; a push when full overwrites
//               the oldest entry and the count saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [ADDR_W-1:0] push_data,
  output logic      [ADDR_W-1:0] top,
  output logic                   empty,
  output logic                   full
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_stack [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_top_idx;

  // r_ptr names the next free slot; when full it also names the oldest entry
  assign w_top_idx = r_ptr - c_PTR_W'(1);
  assign top       = r_stack[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + c_PTR_W'(1);
      if (!full) r_count <= r_count + c_CNT_W'(1);
    end else if (pop && !empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_stack[r_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch program counter with PC-relative branches, external
//               load, stall and return-address stack. PC_ALIGN_CHECK_EN adds
//               a registered misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int                 ADDR_W       = 64,
  parameter int                 COND_W       = 19,
  parameter int                 UNCOND_W     = 26,
  parameter int                 RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input wire logic clk,
  input wire logic reset,
  pc_unit_if.slave bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_underflow;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_off_cond;
  logic [ADDR_W-1:0] w_off_uncond;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_push;
  logic              w_pop;
  logic              w_underflow_next;
  next_pc_sel_e      w_sel;

  assign w_off_cond   = {{(ADDR_W-COND_W){bus.cond_addr19[COND_W-1]}}, bus.cond_addr19};
  assign w_off_uncond = {{(ADDR_W-UNCOND_W){bus.br_addr26[UNCOND_W-1]}}, bus.br_addr26};
  assign w_pc_plus4   = r_pc + ADDR_W'(INSTR_BYTES);
  assign w_target     = r_pc + ((bus.uncond_br ? w_off_uncond : w_off_cond) << WORD_SHIFT);

  // A ret on an empty stack falls through to the sequential PC
  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.pc_rd)                   w_sel = SEL_EXT;
    else if (bus.stall)              w_sel = SEL_HOLD;
    else if (bus.ret && !w_ras_empty) w_sel = SEL_RAS;
    else if (bus.ret)                w_sel = SEL_SEQ;
    else if (bus.br_taken)           w_sel = SEL_BR;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      SEL_EXT:  w_pc_next = bus.pc_ext;
      SEL_HOLD: w_pc_next = r_pc;
      SEL_RAS:  w_pc_next = w_ras_top;
      SEL_BR:   w_pc_next = w_target;
      default:  w_pc_next = w_pc_plus4;
    endcase
  end

  assign w_push           = bus.call && bus.br_taken && !bus.stall && !bus.pc_rd && !bus.ret;
  assign w_pop            = bus.ret && !bus.stall && !bus.pc_rd && !w_ras_empty;
  assign w_underflow_next = bus.ret && !bus.stall && !bus.pc_rd && w_ras_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_VECTOR;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_underflow <= w_underflow_next;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full)
  );

  assign bus.pc_out        = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.ras_empty     = w_ras_empty;
  assign bus.ras_full      = w_ras_full;
  assign bus.ras_underflow = r_underflow;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  // Tracks whatever value the PC register takes, including a held value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= |w_pc_next[1:0];
  end

  assign bus.pc_misalign = r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed scoreboard bench for pc_unit (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic clk;
  logic reset;

  pc_unit_if #(.ADDR_W(64), .COND_W(19), .UNCOND_W(26)) bus ();

  pc_unit #(
    .ADDR_W       (64),
    .COND_W       (19),
    .UNCOND_W     (26),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (64'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected PC, clock once, then compare against the popped entry
  task automatic tick(input string tag, input logic [63:0] exp_pc);
    logic [63:0] e;
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, bus.pc_out, e);
  endtask

  task automatic idle_inputs();
    bus.stall       = 1'b0;
    bus.br_taken    = 1'b0;
    bus.uncond_br   = 1'b0;
    bus.cond_addr19 = '0;
    bus.br_addr26   = '0;
    bus.call        = 1'b0;
    bus.ret         = 1'b0;
    bus.pc_rd       = 1'b0;
    bus.pc_ext      = '0;
  endtask

  task automatic call_fwd(input string tag, input logic [25:0] words, input logic [63:0] exp_pc);
    bus.call = 1'b1; bus.br_taken = 1'b1; bus.uncond_br = 1'b1; bus.br_addr26 = words;
    tick(tag, exp_pc);
    idle_inputs();
  endtask

  task automatic do_ret(input string tag, input logic [63:0] exp_pc);
    bus.ret = 1'b1;
    tick(tag, exp_pc);
    idle_inputs();
  endtask

  task automatic load_pc(input logic [63:0] v);
    bus.pc_rd = 1'b1; bus.pc_ext = v;
    tick("load", v);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_pc", bus.pc_out, 64'd0);
    check("rst_plus4", bus.pc_plus4, 64'd4);
    check("rst_empty", 64'(bus.ras_empty), 64'd1);
    check("rst_full", 64'(bus.ras_full), 64'd0);
    check("rst_uflow", 64'(bus.ras_underflow), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 1; i <= 64; i++) tick("seq", 64'(i * 4));
    check("seq_plus4", bus.pc_plus4, 64'h104);

    // Unconditional and conditional (negative) branches
    bus.br_taken = 1'b1; bus.uncond_br = 1'b1; bus.br_addr26 = 26'd328;
    tick("br_uncond", 64'h620);
    bus.uncond_br = 1'b0; bus.cond_addr19 = -19'sd4;
    tick("br_cond_neg", 64'h610);
    idle_inputs();

    // External load wins over stall; stall then ignores branch/ret
    bus.pc_rd = 1'b1; bus.stall = 1'b1; bus.pc_ext = 64'd45826;
    tick("ext_load", 64'd45826);
    bus.pc_rd = 1'b0; bus.br_taken = 1'b1; bus.ret = 1'b1; bus.call = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall_hold", 64'd45826);
    check("stall_no_uflow", 64'(bus.ras_underflow), 64'd0);
    check("stall_no_push", 64'(bus.ras_empty), 64'd1);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign", 64'(bus.pc_misalign), 64'd1);
`endif
    idle_inputs();

    // Call chain with a same-cycle call+ret on the first return
    load_pc(64'h10);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_clr", 64'(bus.pc_misalign), 64'd0);
`endif
    call_fwd("call1", 26'd124, 64'h200);
    call_fwd("call2", 26'd64, 64'h300);
    call_fwd("call3", 26'd64, 64'h400);
    check("chain_nonempty", 64'(bus.ras_empty), 64'd0);
    bus.call = 1'b1; bus.br_taken = 1'b1; bus.uncond_br = 1'b1; bus.br_addr26 = 26'd4;
    do_ret("ret1", 64'h304);
    do_ret("ret2", 64'h204);
    do_ret("ret3", 64'h14);
    check("chain_empty", 64'(bus.ras_empty), 64'd1);

    // Overflow: five calls at depth four lose the oldest entry
    load_pc(64'h1000);
    for (int i = 1; i <= 5; i++) call_fwd("ovf_call", 26'd1, 64'h1000 + 64'(i * 4));
    check("ovf_full", 64'(bus.ras_full), 64'd1);
    check("ovf_not_empty", 64'(bus.ras_empty), 64'd0);
    do_ret("ovf_ret1", 64'h1014);
    check("ovf_not_full", 64'(bus.ras_full), 64'd0);
    do_ret("ovf_ret2", 64'h1010);
    do_ret("ovf_ret3", 64'h100c);
    do_ret("ovf_ret4", 64'h1008);
    check("ovf_empty", 64'(bus.ras_empty), 64'd1);
    check("pre_uflow", 64'(bus.ras_underflow), 64'd0);
    do_ret("uflow_ret", 64'h100c);
    check("uflow_pulse", 64'(bus.ras_underflow), 64'd1);
    tick("uflow_after", 64'h1010);
    check("uflow_clear", 64'(bus.ras_underflow), 64'd0);

    // Asynchronous reset mid-stream with two stacked entries
    load_pc(64'h2000);
    call_fwd("rst_call1", 26'd1, 64'h2004);
    call_fwd("rst_call2", 26'd1, 64'h2008);
    check("rst_pre_empty", 64'(bus.ras_empty), 64'd0);
    #1 reset = 1'b0;
    #1;
    check("async_rst_pc", bus.pc_out, 64'd0);
    check("async_rst_empty", 64'(bus.ras_empty), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    do_ret("post_rst_ret", 64'd4);
    check("post_rst_uflow", 64'(bus.ras_underflow), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout pc_out=0x%0h", bus.pc_out);
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire
